morse_tx_scheduler: RTL and testbench

MORSE_TX_SCHEDULER -- requirements
Module: morse_tx_scheduler

---
 rtl/morse_pkg.sv | 25 ++
 rtl/morse_rr_arbiter.sv | 57 +++++
 rtl/morse_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_morse_tx_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_pkg
// Description : Shared types and constants for the Morse transmit scheduler:
//               FSM state encoding, letter code type, requester-ID type and
//               the number of requesters.
// Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    localparam int NUM_REQ = 2;

    typedef logic [2:0] letter_t;
    typedef logic       req_id_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/morse_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : morse_rr_arbiter
// Description : Two-requester arbiter for the Morse transmit scheduler.
//               Build option MORSE_SCHED_RR_EN selects round-robin (a tie goes
//               to the requester not granted last; pointer updated on
//               i_update). Without it, fixed priority with i_req[0] highest
//               and no pointer state.
// Ports       : clock, reset     - clock, synchronous active-high reset
//               i_req            - request vector
//               i_update         - pointer update strobe (one per grant)
//               i_upd_id         - ID granted, recorded on i_update
//               o_winner/o_valid - selected requester / any request present
// Revision    : 1.0 - initial release
// ============================================================================
module morse_rr_arbiter
    import morse_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    input  req_id_t            i_upd_id,
    output req_id_t            o_winner,
    output logic               o_valid
);

    assign o_valid = |i_req;

`ifdef MORSE_SCHED_RR_EN
    // Last-granted pointer; resets to 1 so requester 0 wins the first tie.
    req_id_t r_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= i_upd_id;
        end
    end

    always_comb begin
        o_winner = i_req[1];
        if (&i_req) begin
            o_winner = ~r_last;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it requests.
    assign o_winner = ~i_req[0];

    logic w_unused;
    assign w_unused = &{1'b0, clock, reset, i_update, i_upd_id};
`endif

endmodule
`default_nettype wire

// File: rtl/morse_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : morse_tx_scheduler
// Description : Arbitrates two letter requesters onto one Morse transmitter.
//               Issues a one-cycle tx_start/grant, follows the transmitter's
//               busy handshake, then enforces an inter-letter gap of
//               GAP_UNITS*UNIT_CYCLES cycles before accepting the next
//               request. Build option MORSE_SCHED_RR_EN enables round-robin
//               arbitration (default: fixed priority, requester 0 first).
// Ports       : clock, reset        - clock, synchronous active-high reset
//               req[1:0]            - level requests, held until granted
//               letter0, letter1    - letter codes of each requester
//               grant[1:0]          - one-hot one-cycle acceptance pulse
//               tx_start, tx_letter - transmitter start pulse / letter code
//               tx_busy             - transmitter busy
//               idle, active_id     - FSM idle flag / current owner
// Revision    : 1.0 - initial release
// ============================================================================
module morse_tx_scheduler
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int GAP_UNITS   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         letter0,
    input  logic [2:0]         letter1,
    output logic [NUM_REQ-1:0] grant,
    output logic               tx_start,
    output logic [2:0]         tx_letter,
    input  logic               tx_busy,
    output logic               idle,
    output logic               active_id
);

    localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int GAP_W = (GAP_UNITS > 0) ? $clog2(GAP_UNITS + 1) : 1;
    localparam logic [CNT_W-1:0] c_UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [GAP_W-1:0] c_GAP_LAST  = GAP_W'(GAP_UNITS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    letter_t          r_letter;
    req_id_t          r_active;
    logic [CNT_W-1:0] r_unit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;

    req_id_t          w_winner;
    logic             w_valid;
    logic             w_unit_wrap;
    logic             w_gap_done;

    morse_rr_arbiter u_arb (
        .clock    (clock),
        .reset    (reset),
        .i_req    (req),
        .i_update (r_state == ST_ISSUE),
        .i_upd_id (r_active),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    assign w_unit_wrap = (r_unit_cnt == c_UNIT_LAST);
    assign w_gap_done  = w_unit_wrap && (r_gap_cnt == c_GAP_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_start    = 1'b0;
        grant       = '0;
        idle        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                idle = 1'b1;
                if (w_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tx_start    = 1'b1;
                grant       = NUM_REQ'(1) << r_active;
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Winner's letter and ID are captured only at acceptance, so they stay
    // frozen for the whole transaction regardless of input activity.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_letter <= '0;
            r_active <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_valid) begin
            r_letter <= w_winner ? letter1 : letter0;
            r_active <= w_winner;
        end
    end

    // Counters idle at zero outside GAP, so they are already clear on entry.
    always_ff @(posedge clock) begin
        if (reset || (r_state != ST_GAP)) begin
            r_unit_cnt <= '0;
            r_gap_cnt  <= '0;
        end else if (w_unit_wrap) begin
            r_unit_cnt <= '0;
            r_gap_cnt  <= r_gap_cnt + 1'b1;
        end else begin
            r_unit_cnt <= r_unit_cnt + 1'b1;
        end
    end

    assign tx_letter = r_letter;
    assign active_id = r_active;

endmodule
`default_nettype wire

// File: tb/tb_morse_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_tx_scheduler
// Description : Self-checking bench for morse_tx_scheduler with
//               UNIT_CYCLES=4, GAP_UNITS=3 (12-cycle gap). Expected grants
//               come from a transaction-level arbitration model; timing
//               expectations come from the handshake/gap rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_tx_scheduler;

    localparam int UNIT = 4;
    localparam int GAPU = 3;
    localparam int GAP_LEN = UNIT * GAPU;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [2:0] letter0 = 3'd0;
    logic [2:0] letter1 = 3'd0;
    logic       tx_busy = 1'b0;
    logic [1:0] grant;
    logic       tx_start;
    logic [2:0] tx_letter;
    logic       idle;
    logic       active_id;

    int n_err = 0;
    int n_checks = 0;
    int m_last = 1;   // model: last requester granted

    morse_tx_scheduler #(.UNIT_CYCLES(UNIT), .GAP_UNITS(GAPU)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .letter0   (letter0),
        .letter1   (letter1),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_letter (tx_letter),
        .tx_busy   (tx_busy),
        .idle      (idle),
        .active_id (active_id)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration model: single request wins outright; a tie goes to
    // requester 0 (fixed) or to the one not granted last (round-robin).
    function automatic logic pick(input logic [1:0] rq);
        if (rq == 2'b11) begin
`ifdef MORSE_SCHED_RR_EN
            return (m_last == 0);
`else
            return 1'b0;
`endif
        end
        return (rq == 2'b10);
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_active_id"}, active_id, 0);
        chk({tag, "_tx_letter"}, tx_letter, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 2'b00;
        tx_busy = 1'b0;
        step();
        step();
        check_reset_state("reset");
        reset = 1'b0;
        m_last = 1;
    endtask

    // One transaction: present rq, expect issue on the next edge, run the
    // busy handshake (rise after d cycles, held len cycles), then expect
    // exactly GAP_LEN gap cycles. keep=1 holds rq afterwards; otherwise the
    // loser keeps requesting. rst_at>0 resets during that gap cycle.
    task automatic txn(input logic [1:0] rq, input logic [2:0] l0, input logic [2:0] l1,
                       input int d, input int len, input bit keep, input bit gap_poke,
                       input int rst_at, output logic [1:0] left);
        logic       w;
        logic [2:0] el;
        logic [1:0] oh;
        w  = pick(rq);
        el = w ? l1 : l0;
        oh = w ? 2'b10 : 2'b01;
        req = rq;
        letter0 = l0;
        letter1 = l1;
        step();
        chk("issue_tx_start", tx_start, 1);
        chk("issue_grant", grant, oh);
        chk("issue_tx_letter", tx_letter, el);
        chk("issue_active_id", active_id, w);
        chk("issue_idle", idle, 0);
        m_last = w;
        left = keep ? rq : (rq & ~oh);
        req = left;
        letter0 = 3'($urandom);
        letter1 = 3'($urandom);
        for (int i = 0; i < d; i++) begin
            step();
            chk("wait_no_restart", tx_start, 0);
            chk("wait_letter_hold", tx_letter, el);
        end
        tx_busy = 1'b1;
        for (int i = 0; i < len; i++) begin
            step();
            chk("busy_grant_quiet", grant, 0);
            chk("busy_letter_hold", tx_letter, el);
        end
        tx_busy = 1'b0;
        for (int n = 1; n <= GAP_LEN + 1; n++) begin
            step();
            chk("gap_idle", idle, (n == GAP_LEN + 1));
            chk("gap_no_start", tx_start, 0);
            chk("gap_active_hold", active_id, w);
            chk("gap_letter_hold", tx_letter, el);
            if (gap_poke) begin
                req = (n >= 2 && n <= 8) ? 2'b10 : 2'b00;
            end
            if (n == rst_at) begin
                reset = 1'b1;
                step();
                check_reset_state("midgap_reset");
                reset = 1'b0;
                req = 2'b00;
                m_last = 1;
                left = 2'b00;
                return;
            end
        end
    endtask

    initial begin
        logic [1:0] left;
        logic [1:0] pend;
        logic [1:0] rq;

        do_reset();

        // Single request from requester 0 with the reference handshake.
        txn(2'b01, 3'b010, 3'b101, 2, 20, 1'b0, 1'b0, 0, left);

        // Tie held through two transactions.
        do_reset();
        txn(2'b11, 3'b001, 3'b110, 2, 4, 1'b1, 1'b0, 0, left);
        txn(2'b11, 3'b011, 3'b100, 1, 3, 1'b0, 1'b0, 0, left);
        req = 2'b00;
        step();
        chk("tie_drop_idle", idle, 1);

        // Request appearing only during GAP must be ignored.
        txn(2'b01, 3'b111, 3'b000, 1, 2, 1'b0, 1'b1, 0, left);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("poke_no_start", tx_start, 0);
            chk("poke_no_grant", grant, 0);
            chk("poke_idle", idle, 1);
        end

        // Randomized traffic; the loser of each round stays pending.
        pend = 2'b00;
        for (int k = 0; k < 10; k++) begin
            rq = pend | 2'($urandom_range(1, 3));
            txn(rq, 3'($urandom), 3'($urandom), $urandom_range(1, 3),
                $urandom_range(2, 6), 1'b0, 1'b0, 0, left);
            pend = left;
        end
        req = 2'b00;
        if (pend != 2'b00) begin
            txn(pend, 3'($urandom), 3'($urandom), 1, 2, 1'b0, 1'b0, 0, left);
            req = 2'b00;
        end

        // Reset in the fifth gap cycle, then a tie goes to requester 0.
        txn(2'b10, 3'b110, 3'b011, 2, 5, 1'b0, 1'b0, 5, left);
        txn(2'b11, 3'b100, 3'b001, 1, 2, 1'b0, 1'b0, 0, left);
        req = 2'b00;

        // Stall: transmitter never reports busy.
        step();
        req = 2'b10;
        letter1 = 3'b101;
        step();
        chk("stall_tx_start", tx_start, 1);
        chk("stall_grant", grant, 2'b10);
        req = 2'b00;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("stall_no_restart", tx_start, 0);
            chk("stall_letter_hold", tx_letter, 3'b101);
            chk("stall_not_idle", idle, 0);
        end
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
